// File: rtl/traffic_sensor.sv
// EW vehicle queue sensor: synchronized, debounced loop detectors feed a saturating
// queue counter and a request FSM. Optional max-green timeout: TRAFFIC_SENSOR_MAXGREEN_EN.
module traffic_sensor #(
  parameter int DEBOUNCE = 3,
  parameter int QMAX     = 15,
  parameter int MAXGREEN = 20
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_arrive,
  input  logic       car_depart,
  input  logic [1:0] ew,
  output logic       X,
  output logic [3:0] queue_cnt,
  output logic       overflow
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVE, RELEASE} state_t;

  // Index 0 is the arrival detector, index 1 the departure detector.
  logic [1:0]    meta, sync, deb, deb_d;
  logic [CW-1:0] db_cnt [2];
  logic          arrive_evt, depart_evt, green, red, timeout;
  state_t        state, next_state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      meta  <= '0;
      sync  <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      meta  <= {car_depart, car_arrive};
      sync  <= meta;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE - 1)) begin
          deb[i]    <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign green      = (ew == 2'd2);
  assign red        = (ew == 2'd0) || (ew == 2'd3);
  assign arrive_evt = deb[0] & ~deb_d[0];
  assign depart_evt = deb[1] & ~deb_d[1] & green;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      queue_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (arrive_evt && !depart_evt && queue_cnt != 4'(QMAX))
        queue_cnt <= queue_cnt + 4'd1;
      else if (depart_evt && !arrive_evt && queue_cnt != 4'd0)
        queue_cnt <= queue_cnt - 4'd1;
      if (arrive_evt && queue_cnt == 4'(QMAX))
        overflow <= 1'b1;
    end
  end

`ifdef TRAFFIC_SENSOR_MAXGREEN_EN
  localparam int TW = $clog2(MAXGREEN + 1);
  logic [TW-1:0] green_timer;

  // Held at zero outside SERVE, so it starts from zero on every SERVE entry.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)               green_timer <= '0;
    else if (state != SERVE) green_timer <= '0;
    else                     green_timer <= green_timer + 1'b1;
  end

  assign timeout = (state == SERVE) && (green_timer == TW'(MAXGREEN - 1));
`else
  localparam int unused_maxgreen = MAXGREEN;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (queue_cnt != 4'd0)            next_state = REQUEST;
      REQUEST: if (green)                        next_state = SERVE;
      SERVE:   if (queue_cnt == 4'd0 || timeout) next_state = RELEASE;
      RELEASE: if (red)                          next_state = IDLE;
      default:                                   next_state = IDLE;
    endcase
  end

  assign X = (state == REQUEST) || (state == SERVE);

endmodule

// File: tb/tb_traffic_sensor.sv
// Directed self-checking bench for traffic_sensor with hand-computed expected values.
module tb_traffic_sensor;

  logic       clock = 1'b0;
  logic       clear;
  logic       car_arrive, car_depart;
  logic [1:0] ew;
  logic       X;
  logic [3:0] queue_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  traffic_sensor #(.DEBOUNCE(3), .QMAX(15), .MAXGREEN(20)) dut (
    .clock(clock), .clear(clear), .car_arrive(car_arrive), .car_depart(car_depart),
    .ew(ew), .X(X), .queue_cnt(queue_cnt), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Debounced rise lands on edge 5, queue update on edge 6; low half lets the detector settle.
  task automatic arrive_pulse();
    car_arrive = 1'b1;
    tick(5);
    car_arrive = 1'b0;
    tick(5);
  endtask

  task automatic depart_pulse();
    car_depart = 1'b1;
    tick(5);
    car_depart = 1'b0;
    tick(5);
  endtask

  task automatic do_clear();
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    tick(1);
  endtask

  initial begin
    clear = 1'b1; car_arrive = 1'b0; car_depart = 1'b0; ew = 2'd0;
    #11;
    check("reset_x", X, 0);
    check("reset_q", queue_cnt, 0);
    check("reset_ov", overflow, 0);
    clear = 1'b0;
    tick(1);

    // Single car: arrival timing, service, departure, release.
    car_arrive = 1'b1;
    tick(5);
    check("car1_q_edge5", queue_cnt, 0);
    tick(1);
    check("car1_q_edge6", queue_cnt, 1);
    check("car1_x_edge6", X, 0);
    tick(1);
    check("car1_x_edge7", X, 1);
    tick(3);
    car_arrive = 1'b0;
    ew = 2'd2;
    tick(10);
    check("car1_serve_x", X, 1);
    car_depart = 1'b1;
    tick(6);
    check("car1_depart_q", queue_cnt, 0);
    check("car1_depart_x_edge6", X, 1);
    tick(1);
    check("car1_release_x", X, 0);
    tick(3);
    car_depart = 1'b0;
    ew = 2'd0;
    tick(10);
    check("car1_idle_x", X, 0);
    check("car1_idle_q", queue_cnt, 0);

    // Glitch: two synchronized high samples then low.
    car_arrive = 1'b1;
    tick(2);
    car_arrive = 1'b0;
    tick(12);
    check("glitch_q", queue_cnt, 0);
    check("glitch_x", X, 0);

    // Depart while red is discarded.
    arrive_pulse();
    check("red_arrive_q", queue_cnt, 1);
    check("red_request_x", X, 1);
    depart_pulse();
    check("red_depart_q", queue_cnt, 1);

    // Simultaneous arrival and depart under green.
    ew = 2'd2;
    tick(2);
    car_arrive = 1'b1; car_depart = 1'b1;
    tick(5);
    car_arrive = 1'b0; car_depart = 1'b0;
    tick(5);
    check("simul_q", queue_cnt, 1);
    check("simul_x", X, 1);
    depart_pulse();
    check("serve_depart_q", queue_cnt, 0);
    check("serve_depart_x", X, 0);

    // Arrival during RELEASE counts but does not request; ew=3 exits as red.
    arrive_pulse();
    check("release_arrive_q", queue_cnt, 1);
    check("release_arrive_x", X, 0);
    ew = 2'd3;
    tick(1);
    check("ew3_idle_x", X, 0);
    tick(1);
    check("ew3_request_x", X, 1);

    // Saturation and overflow.
    do_clear();
    check("clr_q", queue_cnt, 0);
    ew = 2'd0;
    for (int i = 0; i < 15; i++) arrive_pulse();
    check("sat15_q", queue_cnt, 15);
    check("sat15_ov", overflow, 0);
    for (int i = 0; i < 2; i++) arrive_pulse();
    check("sat17_q", queue_cnt, 15);
    check("sat17_ov", overflow, 1);
    check("sat17_x", X, 1);
    #3 clear = 1'b1;
    #1;
    check("sat_clr_q", queue_cnt, 0);
    check("sat_clr_ov", overflow, 0);
    check("sat_clr_x", X, 0);
    #2 clear = 1'b0;
    tick(1);

    // Asynchronous clear while in SERVE, between edges.
    ew = 2'd2;
    arrive_pulse();
    check("serve_pre_q", queue_cnt, 1);
    check("serve_pre_x", X, 1);
    #3 clear = 1'b1;
    #1;
    check("async_clr_x", X, 0);
    check("async_clr_q", queue_cnt, 0);
    #2 clear = 1'b0;
    tick(1);
    check("post_clr_x", X, 0);
    arrive_pulse();
    check("resume_q", queue_cnt, 1);
    check("resume_x", X, 1);

`ifdef TRAFFIC_SENSOR_MAXGREEN_EN
    // Max green timeout with vehicles still queued.
    do_clear();
    ew = 2'd0;
    for (int i = 0; i < 5; i++) arrive_pulse();
    check("mg_q", queue_cnt, 5);
    check("mg_request_x", X, 1);
    ew = 2'd2;
    tick(1);
    tick(19);
    check("mg_x_19", X, 1);
    tick(1);
    check("mg_x_20", X, 0);
    check("mg_q_kept", queue_cnt, 5);
    ew = 2'd0;
    tick(1);
    check("mg_idle_x", X, 0);
    tick(1);
    check("mg_rerequest_x", X, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
